ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive side feeds the piano's note decoder. On a one-cycle request it inhibits the bus, shifts out one command byte (LSB first, odd parity, stop), and checks the device's acknowledge. Typical traffic is the LED command 0xED plus its argument, and reset 0xFF. It drives the shared PS/2 clock and data lines as open-drain enables. While it is busy, the PS/2 receive path treats its own traffic as non-keyboard.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame layout, command bytes, parity helper.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int unsigned PS2_FRAME_LEN   = 11;
  // Bits shifted by the host after the start bit: data, parity, stop.
  localparam int unsigned PS2_PAYLOAD_LEN = PS2_FRAME_LEN - 1;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_t;

  // Host-to-device payload, LSB (data[0]) shifted first.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad line plus falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Resync the pad and keep one cycle of history; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= line;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, shift byte, check acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15_000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iSend,
  input  logic [7:0] iData,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Data,
  output logic       oPs2_Clk_Oe,
  output logic       oPs2_Data_Oe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int unsigned INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned CNT_MAX  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = $clog2(PS2_PAYLOAD_LEN);
  localparam int unsigned LAST_IDX = PS2_PAYLOAD_LEN - 1;

  ps2_state_t                 state;
  ps2_state_t                 next_state;
  ps2_frame_t                 frame;
  logic [PS2_PAYLOAD_LEN-1:0] frame_bits;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic                       nack;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;

  logic inhibit_done;
  logic timeout_hit;
  logic lines_idle;

  logic clk_oe_d;
  logic data_oe_d;
  logic busy_d;
  logic done_d;
  logic error_d;

  ps2_line_sync u_clk_sync (
    .clk    (iClk),
    .reset  (iReset),
    .line   (iPs2_Clk),
    .level  (clk_level),
    .fall_c (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (iClk),
    .reset  (iReset),
    .line   (iPs2_Data),
    .level  (data_level),
    .fall_c (unused_data_fall)
  );

  assign frame_bits   = frame;
  assign inhibit_done = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign timeout_hit  = ((state == ST_SHIFT) || (state == ST_ACK)) &&
                        (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign lines_idle   = clk_level & data_level;

  // State register.
  always_ff @(posedge iClk) begin
    if (iReset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; timeout wins over a coincident clock edge.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (iSend) next_state = ST_INHIBIT;
      ST_INHIBIT:   if (inhibit_done) next_state = ST_START;
      ST_START:     next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (timeout_hit)                                 next_state = ST_IDLE;
        else if (clk_fall && (idx == IDX_W'(LAST_IDX)))  next_state = ST_ACK;
      end
      ST_ACK: begin
        if (timeout_hit)   next_state = ST_IDLE;
        else if (clk_fall) next_state = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: if (lines_idle) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    clk_oe_d  = 1'b0;
    data_oe_d = oPs2_Data_Oe;
    busy_d    = (next_state != ST_IDLE);
    done_d    = 1'b0;
    error_d   = oError;
    case (state)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (iSend) begin
          clk_oe_d = 1'b1;
          error_d  = 1'b0;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = inhibit_done;
      end
      ST_START: data_oe_d = 1'b1;
      ST_SHIFT, ST_ACK: begin
        if (timeout_hit) begin
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else if (clk_fall && (state == ST_SHIFT)) begin
          data_oe_d = ~frame_bits[idx];
        end
      end
      ST_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (lines_idle) begin
          done_d  = 1'b1;
          error_d = nack;
        end
      end
      default: data_oe_d = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oPs2_Clk_Oe  <= 1'b0;
      oPs2_Data_Oe <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
    end else begin
      oPs2_Clk_Oe  <= clk_oe_d;
      oPs2_Data_Oe <= data_oe_d;
      oBusy        <= busy_d;
      oDone        <= done_d;
      oError       <= error_d;
    end
  end

  // Datapath: byte capture, shared inhibit/timeout counter, bit index, ack sample.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      frame <= '0;
      cnt   <= '0;
      idx   <= '0;
      nack  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && iSend) begin
        frame <= '{stop: 1'b1, parity: odd_parity(iData), data: iData};
        nack  <= 1'b0;
      end
      case (state)
        ST_INHIBIT:       cnt <= inhibit_done ? '0 : cnt + CNT_W'(1);
        ST_SHIFT, ST_ACK: cnt <= (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) ? cnt : cnt + CNT_W'(1);
        default:          cnt <= '0;
      endcase
      if (state == ST_START) begin
        idx <= '0;
      end else if ((state == ST_SHIFT) && clk_fall && (idx != IDX_W'(LAST_IDX))) begin
        idx <= idx + IDX_W'(1);
      end
      if ((state == ST_ACK) && clk_fall) nack <= data_level;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines, table plus random frames.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TIMEOUT_US = 15_000;
  localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int HALF = 40;  // 12.5 kHz device clock at 1 MHz system clock

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ps2_clk;
  logic       ps2_data;
  logic       clk_oe;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mon_inhibit = 0;
  int mon_start = 0;
  int mon_done = 0;
  int mon_start_cyc = 0;
  int mon_done_cyc = 0;

  typedef struct {
    logic [7:0] b;
    bit         lvl;   // level the device presents at the ack edge (0 = ACK)
    bit         par;   // expected parity bit on the wire
    bit         err;   // expected oError
  } vec_t;

  vec_t vecs[5];

  // Open-drain wired-AND of host and device.
  assign ps2_clk  = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .iClk         (clk),
    .iReset       (reset),
    .iSend        (send),
    .iData        (data),
    .iPs2_Clk     (ps2_clk),
    .iPs2_Data    (ps2_data),
    .oPs2_Clk_Oe  (clk_oe),
    .oPs2_Data_Oe (data_oe),
    .oBusy        (busy),
    .oDone        (done),
    .oError       (error)
  );

  always #5 clk = ~clk;

  // Passive bus monitor: inhibit cycles, start cycles, done pulses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clk_oe && !data_oe) mon_inhibit <= mon_inhibit + 1;
    if (clk_oe && data_oe) begin
      mon_start     <= mon_start + 1;
      mon_start_cyc <= cyc;
    end
    if (done) begin
      mon_done     <= mon_done + 1;
      mon_done_cyc <= cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic bit ref_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    send = 1'b1;
    data = b;
    @(negedge clk);
    send = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_clk_oe", clk_oe, 1);
  endtask

  // Device: wait for request-to-send, clock nbits bits (sampling on rising edges), then optional ack pulse.
  task automatic device(input int nbits, input bit do_ack, input bit ack_level,
                        output logic [9:0] cap, output bit seen);
    seen = 1'b0;
    cap  = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && ps2_data === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      repeat (20) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        cap[b] = ps2_data;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      if (do_ack) begin
        dev_data_low = (ack_level == 1'b0);
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit got, output logic err);
    got = 1'b0;
    err = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        err = error;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit lvl, input bit exp_par,
                           input bit exp_err, input string tag);
    logic [9:0] cap;
    bit         seen;
    bit         got;
    logic       err;
    int         d0, i0, s0;
    d0 = mon_done;
    i0 = mon_inhibit;
    s0 = mon_start;
    send_byte(b);
    fork
      device(10, 1'b1, lvl, cap, seen);
      wait_done(3000, got, err);
    join
    repeat (3) @(negedge clk);
    check({tag, "_request"}, seen, 1);
    check({tag, "_data"}, cap[7:0], b);
    check({tag, "_parity"}, cap[8], exp_par);
    check({tag, "_stop"}, cap[9], 1);
    check({tag, "_done"}, got, 1);
    check({tag, "_error"}, err, exp_err);
    check({tag, "_error_hold"}, error, exp_err);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_oe_after"}, {clk_oe, data_oe}, 0);
    check({tag, "_inhibit_cycles"}, mon_inhibit - i0, INHIBIT_CYCLES);
    check({tag, "_start_cycles"}, mon_start - s0, 1);
    check({tag, "_done_pulses"}, mon_done - d0, 1);
  endtask

  initial begin
    logic [9:0] cap;
    bit         seen;
    bit         got;
    logic       err;
    int         d0, s0;
    logic [7:0] rb;
    bit         rl;

    vecs[0] = '{PS2_CMD_SET_LED, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00,           1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01,           1'b0, 1'b0, 1'b0};
    vecs[3] = '{PS2_CMD_RESET,   1'b0, 1'b1, 1'b0};
    vecs[4] = '{PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b1};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].b, vecs[i].lvl, vecs[i].par, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Random bytes and ack levels against the reference model.
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rl = ($urandom_range(0, 3) == 0);
      run_frame(rb, rl, ref_parity(rb), rl, $sformatf("rand%0d", k));
    end

    // Device never clocks: timeout.
    d0 = mon_done;
    send_byte(8'hA5);
    fork
      device(0, 1'b0, 1'b0, cap, seen);
      wait_done(TIMEOUT_CYCLES + 2000, got, err);
    join
    @(negedge clk);
    check("to_request", seen, 1);
    check("to_done", got, 1);
    check("to_error", err, 1);
    check("to_latency", mon_done_cyc - mon_start_cyc, TIMEOUT_CYCLES + 1);
    check("to_busy_next", busy, 0);
    check("to_oe_next", {clk_oe, data_oe}, 0);
    check("to_done_pulses", mon_done - d0, 1);

    // Reset while bit 4 is on the wire.
    d0 = mon_done;
    send_byte(8'h2C);
    device(4, 1'b0, 1'b0, cap, seen);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_bits", cap[3:0], 4'hC);
    check("mid_data_oe", data_oe, 1);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", {clk_oe, data_oe}, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_rst_no_done", mon_done - d0, 0);
    run_frame(PS2_CMD_RESET, 1'b0, 1'b1, 1'b0, "after_rst");

    // Second request while busy is dropped.
    d0 = mon_done;
    s0 = mon_start;
    send_byte(8'h96);
    fork
      device(10, 1'b1, 1'b0, cap, seen);
      wait_done(3000, got, err);
      begin
        repeat (300) @(negedge clk);
        send = 1'b1;
        data = 8'h55;
        @(negedge clk);
        send = 1'b0;
      end
    join
    repeat (400) @(negedge clk);
    check("busy_ign_data", cap[7:0], 8'h96);
    check("busy_ign_done", got, 1);
    check("busy_ign_error", err, 0);
    check("busy_ign_pulses", mon_done - d0, 1);
    check("busy_ign_frames", mon_start - s0, 1);
    check("busy_ign_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
